isa_io_cycle_engine: RTL and testbench

Parametrised ISA I/O cycle generator between the HPS-side register interface and the ISA riser bus. It accepts a single read or write request with a one-cycle handshake and latches address and data. It then runs a timed ISA I/O cycle: address setup, IOR#/IOW# strobe, optional IOCHRDY wait-state stretching with timeout, and hold. It returns read data and a completion/error status.

---
 rtl/isa_io_cycle_engine_if.sv | 32 +++
 rtl/isa_io_cycle_engine.sv | 176 +++++++++++++++++
 tb/tb_isa_io_cycle_engine.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/isa_io_cycle_engine_if.sv
// Host request/response and ISA riser signals of the ISA I/O cycle engine.
// The master side is the requester plus the bus model driving isa_data_in/iochrdy.
interface isa_io_cycle_engine_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  timeout_err;
  logic [ADDR_WIDTH-1:0] isa_addr;
  logic [DATA_WIDTH-1:0] isa_data_out;
  logic                  isa_data_oe;
  logic [DATA_WIDTH-1:0] isa_data_in;
  logic                  iow_n;
  logic                  ior_n;
  logic                  iochrdy;

  modport master (
    output req, we, addr_in, wdata, isa_data_in, iochrdy,
    input  busy, ack, rdata, timeout_err, isa_addr, isa_data_out, isa_data_oe, iow_n, ior_n
  );

  modport slave (
    input  req, we, addr_in, wdata, isa_data_in, iochrdy,
    output busy, ack, rdata, timeout_err, isa_addr, isa_data_out, isa_data_oe, iow_n, ior_n
  );
endinterface

// File: rtl/isa_io_cycle_engine.sv
// Single-transaction ISA I/O cycle generator: setup, IOR#/IOW# strobe with IOCHRDY
// wait-state stretching and timeout, hold, then a one-cycle ack. All outputs registered.
module isa_io_cycle_engine #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned STROBE_CYCLES  = 8,
  parameter int unsigned HOLD_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic                 clk,
  input logic                 reset,
  isa_io_cycle_engine_if.slave bus
);

  // One counter serves every phase; in STROBE it spans minimum width plus extension.
  localparam int unsigned StrobeLast  = STROBE_CYCLES - 1;
  localparam int unsigned TimeoutLast = STROBE_CYCLES - 1 + TIMEOUT_CYCLES;
  localparam int unsigned HoldLast    = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam int unsigned MaxSh       = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int unsigned CntMax      = (MaxSh > TimeoutLast) ? MaxSh : TimeoutLast;
  localparam int unsigned CntW        = $clog2(CntMax + 1) + 1;

  localparam logic [CntW-1:0] SetupLastC   = CntW'(SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] StrobeLastC  = CntW'(StrobeLast);
  localparam logic [CntW-1:0] TimeoutLastC = CntW'(TimeoutLast);
  localparam logic [CntW-1:0] HoldLastC    = CntW'(HoldLast);
  localparam logic [CntW-1:0] CntOne       = CntW'(1);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  oe_q, oe_d;
  logic                  iow_n_q, iow_n_d;
  logic                  ior_n_q, ior_n_d;
  logic                  busy_q, busy_d;
  logic                  ack_q, ack_d;
  logic                  terr_q, terr_d;
  logic [1:0]            sync_q;
  logic                  rdy_s;
  logic                  end_strobe;

  assign rdy_s = sync_q[1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    rdata_d    = rdata_q;
    oe_d       = oe_q;
    iow_n_d    = iow_n_q;
    ior_n_d    = ior_n_q;
    busy_d     = busy_q;
    ack_d      = 1'b0;
    terr_d     = terr_q;
    end_strobe = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          state_d = StSetup;
          cnt_d   = '0;
          we_d    = bus.we;
          addr_d  = bus.addr_in;
          busy_d  = 1'b1;
          terr_d  = 1'b0;
          if (bus.we) begin
            dout_d = bus.wdata;
            oe_d   = 1'b1;
          end
        end
      end
      StSetup: begin
        if (cnt_q == SetupLastC) begin
          state_d = StStrobe;
          cnt_d   = '0;
          if (we_q) iow_n_d = 1'b0;
          else      ior_n_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStrobe: begin
        // Ready wins over timeout when both land on the same cycle.
        if (cnt_q >= StrobeLastC) begin
          if (rdy_s) begin
            end_strobe = 1'b1;
          end else if (cnt_q >= TimeoutLastC) begin
            end_strobe = 1'b1;
            terr_d     = 1'b1;
          end
        end
        if (end_strobe) begin
          iow_n_d = 1'b1;
          ior_n_d = 1'b1;
          cnt_d   = '0;
          if (!we_q) rdata_d = bus.isa_data_in;
          if (HOLD_CYCLES == 0) begin
            state_d = StDone;
            ack_d   = 1'b1;
            oe_d    = 1'b0;
          end else begin
            state_d = StHold;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHold: begin
        if (cnt_q == HoldLastC) begin
          state_d = StDone;
          cnt_d   = '0;
          ack_d   = 1'b1;
          oe_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      oe_q    <= 1'b0;
      iow_n_q <= 1'b1;
      ior_n_q <= 1'b1;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      terr_q  <= 1'b0;
      sync_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      oe_q    <= oe_d;
      iow_n_q <= iow_n_d;
      ior_n_q <= ior_n_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      terr_q  <= terr_d;
      sync_q  <= {sync_q[0], bus.iochrdy};
    end
  end

  assign bus.busy         = busy_q;
  assign bus.ack          = ack_q;
  assign bus.rdata        = rdata_q;
  assign bus.timeout_err  = terr_q;
  assign bus.isa_addr     = addr_q;
  assign bus.isa_data_out = dout_q;
  assign bus.isa_data_oe  = oe_q;
  assign bus.iow_n        = iow_n_q;
  assign bus.ior_n        = ior_n_q;

endmodule

// File: tb/tb_isa_io_cycle_engine.sv
// Directed bench for isa_io_cycle_engine with default parameters; cycle k is the
// k-th clock period after the accept edge, sampled 1 time unit after its opening edge.
module tb_isa_io_cycle_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  isa_io_cycle_engine_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

  isa_io_cycle_engine #(
    .ADDR_WIDTH    (16),
    .DATA_WIDTH    (16),
    .SETUP_CYCLES  (2),
    .STROBE_CYCLES (8),
    .HOLD_CYCLES   (2),
    .TIMEOUT_CYCLES(256)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Per-transaction observations
  int          n_acks, ack_cyc, iow_first, iow_last, ior_first, ior_last, oe_first, oe_last;
  logic [15:0] rdata_ack, addr_ack, addr_c1, dout_c1;
  logic        terr_ack, terr_c1, both_low, busy_post;
  logic        rst_iow, rst_oe, rst_busy;
  logic [15:0] rst_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one request in cycle 0 and observe cycles 1..ncyc. iochrdy is low for the
  // first rdy_low sampling edges; with ramp the bus data in cycle k is base+k.
  task automatic run_txn(input logic t_we, input logic [15:0] t_addr, input logic [15:0] t_wdata,
                         input int rdy_low, input logic [15:0] base, input logic ramp,
                         input int ncyc, input int req2_cyc, input int rst_cyc);
    n_acks = 0; ack_cyc = -1; iow_first = -1; iow_last = -1; ior_first = -1; ior_last = -1;
    oe_first = -1; oe_last = -1; both_low = 1'b0; busy_post = 1'bx; terr_ack = 1'bx;
    bus.req = 1'b1; bus.we = t_we; bus.addr_in = t_addr; bus.wdata = t_wdata;
    bus.iochrdy = (rdy_low <= 0);
    bus.isa_data_in = base;
    @(posedge clk); #1;
    bus.req = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      if (k == 1) begin
        addr_c1 = bus.isa_addr; dout_c1 = bus.isa_data_out; terr_c1 = bus.timeout_err;
      end
      if (!bus.iow_n) begin if (iow_first < 0) iow_first = k; iow_last = k; end
      if (!bus.ior_n) begin if (ior_first < 0) ior_first = k; ior_last = k; end
      if (bus.isa_data_oe) begin if (oe_first < 0) oe_first = k; oe_last = k; end
      if (!bus.iow_n && !bus.ior_n) both_low = 1'b1;
      if (ack_cyc > 0 && k == ack_cyc + 1) busy_post = bus.busy;
      if (bus.ack) begin
        n_acks++;
        if (ack_cyc < 0) begin
          ack_cyc = k; rdata_ack = bus.rdata; terr_ack = bus.timeout_err; addr_ack = bus.isa_addr;
        end
      end
      if (k == rst_cyc + 1) begin
        rst_iow = bus.iow_n; rst_oe = bus.isa_data_oe; rst_busy = bus.busy; rst_addr = bus.isa_addr;
      end
      bus.iochrdy = (k >= rdy_low);
      bus.isa_data_in = ramp ? base + 16'(k) : base;
      bus.req = (k == req2_cyc);
      if (k == req2_cyc) begin
        bus.we = 1'b1; bus.addr_in = 16'h0300; bus.wdata = 16'h1111;
      end
      reset = (k == rst_cyc);
      @(posedge clk); #1;
    end
    bus.req = 1'b0;
    reset = 1'b0;
    bus.iochrdy = 1'b1;
  endtask

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr_in = '0; bus.wdata = '0;
    bus.isa_data_in = '0; bus.iochrdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_iow_n", bus.iow_n, 1'b1);
    check_eq("rst_ior_n", bus.ior_n, 1'b1);
    check_eq("rst_oe", bus.isa_data_oe, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_ack", bus.ack, 1'b0);
    check_eq("rst_addr", bus.isa_addr, 16'h0000);
    check_eq("rst_rdata", bus.rdata, 16'h0000);
    check_eq("rst_terr", bus.timeout_err, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic write
    run_txn(1'b1, 16'h0220, 16'hA55A, 0, 16'h0000, 1'b0, 16, -1, -1);
    check_eq("wr_addr_c1", addr_c1, 16'h0220);
    check_eq("wr_dout_c1", dout_c1, 16'hA55A);
    check_eq("wr_oe_first", oe_first, 1);
    check_eq("wr_oe_last", oe_last, 12);
    check_eq("wr_iow_first", iow_first, 3);
    check_eq("wr_iow_last", iow_last, 10);
    check_eq("wr_ior_none", ior_first, -1);
    check_eq("wr_acks", n_acks, 1);
    check_eq("wr_ack_cyc", ack_cyc, 13);
    check_eq("wr_terr", terr_ack, 1'b0);
    check_eq("wr_busy_post", busy_post, 1'b0);

    // Basic read
    run_txn(1'b0, 16'h022A, 16'hFFFF, 0, 16'h00AA, 1'b0, 16, -1, -1);
    check_eq("rd_ior_first", ior_first, 3);
    check_eq("rd_ior_last", ior_last, 10);
    check_eq("rd_iow_none", iow_first, -1);
    check_eq("rd_oe_never", oe_first, -1);
    check_eq("rd_ack_cyc", ack_cyc, 13);
    check_eq("rd_rdata", rdata_ack, 16'h00AA);
    check_eq("rd_addr", addr_ack, 16'h022A);

    // iochrdy low for 20 edges: rdy_s rises in cycle 22, strobe ends at its closing edge
    run_txn(1'b0, 16'h0230, 16'h0000, 20, 16'h1000, 1'b1, 30, -1, -1);
    check_eq("st_ior_first", ior_first, 3);
    check_eq("st_ior_last", ior_last, 22);
    check_eq("st_ack_cyc", ack_cyc, 25);
    check_eq("st_rdata", rdata_ack, 16'h1016);
    check_eq("st_terr", terr_ack, 1'b0);
    check_eq("st_both_low", both_low, 1'b0);

    // iochrdy stuck low: 8 + 256 strobe cycles then timeout
    run_txn(1'b0, 16'h0240, 16'h0000, 100000, 16'h2000, 1'b1, 280, -1, -1);
    check_eq("to_ior_last", ior_last, 266);
    check_eq("to_ack_cyc", ack_cyc, 269);
    check_eq("to_terr", terr_ack, 1'b1);
    check_eq("to_rdata", rdata_ack, 16'h210A);
    check_eq("to_terr_idle", bus.timeout_err, 1'b1);

    // Good write clears the error
    run_txn(1'b1, 16'h0250, 16'h0F0F, 0, 16'h0000, 1'b0, 16, -1, -1);
    check_eq("ok_terr_c1", terr_c1, 1'b0);
    check_eq("ok_terr_ack", terr_ack, 1'b0);
    check_eq("ok_ack_cyc", ack_cyc, 13);
    check_eq("ok_rdata_kept", rdata_ack, 16'h210A);

    // Second request while busy is dropped
    run_txn(1'b1, 16'h0220, 16'hA55A, 0, 16'h0000, 1'b0, 30, 5, -1);
    check_eq("bz_acks", n_acks, 1);
    check_eq("bz_ack_cyc", ack_cyc, 13);
    check_eq("bz_addr", addr_ack, 16'h0220);
    check_eq("bz_iow_last", iow_last, 10);
    check_eq("bz_busy_post", busy_post, 1'b0);
    check_eq("bz_idle_busy", bus.busy, 1'b0);

    // Reset during the write strobe
    run_txn(1'b1, 16'h0260, 16'h3C3C, 0, 16'h0000, 1'b0, 25, -1, 6);
    check_eq("rs_iow_n", rst_iow, 1'b1);
    check_eq("rs_oe", rst_oe, 1'b0);
    check_eq("rs_busy", rst_busy, 1'b0);
    check_eq("rs_addr", rst_addr, 16'h0000);
    check_eq("rs_acks", n_acks, 0);

    run_txn(1'b0, 16'h0270, 16'h0000, 0, 16'h0055, 1'b0, 16, -1, -1);
    check_eq("pr_ack_cyc", ack_cyc, 13);
    check_eq("pr_rdata", rdata_ack, 16'h0055);
    check_eq("pr_ior_last", ior_last, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
